// File: rtl/branch_resolve_unit_pkg.sv
// ============================================================================
//  branch_resolve_unit_pkg
//  Opcode, funct3 and FSM encodings shared by the branch resolve unit.
//  Rev 1.0
// ============================================================================
`default_nettype none

package branch_resolve_unit_pkg;

    localparam logic [6:0] B_TYPE      = 7'b1100011;
    localparam logic [6:0] J_TYPE      = 7'b1101111;
    localparam logic [6:0] I_TYPE_JALR = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

endpackage

`default_nettype wire

// File: rtl/branch_resolve_unit_comparator.sv
// ============================================================================
//  branch_comparator
//  Conditional-branch direction evaluation; legal=0 for reserved funct3.
//  Rev 1.0
// ============================================================================
`default_nettype none

module branch_comparator
    import branch_resolve_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        taken,
    output logic        legal
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (rs1 == rs2);
    assign w_lt  = ($signed(rs1) < $signed(rs2));
    assign w_ltu = (rs1 < rs2);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (funct3)
            F3_BEQ:  taken = w_eq;
            F3_BNE:  taken = !w_eq;
            F3_BLT:  taken = w_lt;
            F3_BGE:  taken = !w_lt;
            F3_BLTU: taken = w_ltu;
            F3_BGEU: taken = !w_ltu;
            default: legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
//  branch_resolve_unit
//  Execute-stage branch/jump resolver: redirect FSM, predictor update, stats.
//  Rev 1.0
// ============================================================================
`default_nettype none

module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int IDX_W = 10,
    parameter int TAG_W = 20,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_e,
    input  logic              stall_e,
    input  logic [31:0]       instr_e,
    input  logic [31:0]       pc_e,
    input  logic [31:0]       rs1_val,
    input  logic [31:0]       rs2_val,
    input  logic [31:0]       imm_e,
    input  logic [31:0]       pc_d,
    input  logic              redirect_rdy,
    output logic              redirect_vld,
    output logic [31:0]       redirect_pc,
    output logic              flush_d_e,
    output logic              upd_vld,
    output logic [IDX_W-1:0]  upd_idx,
    output logic [TAG_W-1:0]  upd_tag,
    output logic [31:0]       upd_target,
    output logic              upd_taken,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [31:0]      r_redirect_pc;
    logic             r_upd_vld;
    logic [IDX_W-1:0] r_upd_idx;
    logic [TAG_W-1:0] r_upd_tag;
    logic [31:0]      r_upd_target;
    logic             r_upd_taken;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_is_b;
    logic        w_is_jal;
    logic        w_is_jalr;
    logic        w_cmp_taken;
    logic        w_cmp_legal;
    logic        w_ctl;
    logic        w_taken;
    logic [31:0] w_target;
    logic [31:0] w_jalr_sum;
    logic [31:0] w_next_pc;
    logic        w_mispredict;
    logic        w_resolve;
    logic        w_unused_ok;

    assign w_opcode  = instr_e[6:0];
    assign w_funct3  = instr_e[14:12];
    assign w_is_b    = (w_opcode == B_TYPE);
    assign w_is_jal  = (w_opcode == J_TYPE);
    assign w_is_jalr = (w_opcode == I_TYPE_JALR);

    branch_comparator u_cmp (
        .funct3 (w_funct3),
        .rs1    (rs1_val),
        .rs2    (rs2_val),
        .taken  (w_cmp_taken),
        .legal  (w_cmp_legal)
    );

    assign w_ctl        = (w_is_b && w_cmp_legal) || w_is_jal || w_is_jalr;
    assign w_taken      = w_is_b ? w_cmp_taken : 1'b1;
    assign w_jalr_sum   = rs1_val + imm_e;
    assign w_target     = w_is_jalr ? {w_jalr_sum[31:1], 1'b0} : (pc_e + imm_e);
    assign w_next_pc    = w_taken ? w_target : (pc_e + 32'd4);
    assign w_mispredict = (w_next_pc != pc_d);

    // Wrong-path instructions sit in E for the whole redirect, accept cycle included.
    assign w_resolve = valid_e && !stall_e && w_ctl && (r_state == S_IDLE) && !redirect_vld;

    assign w_unused_ok = &{1'b0, instr_e[31:15], instr_e[11:7], pc_e};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_resolve && w_mispredict) w_state_nxt = S_HOLD;
            S_HOLD:  if (redirect_rdy)              w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        redirect_vld = 1'b0;
        flush_d_e    = 1'b0;
        redirect_pc  = 32'd0;
        if (r_state == S_HOLD) begin
            redirect_vld = 1'b1;
            flush_d_e    = 1'b1;
            redirect_pc  = r_redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_pc <= 32'd0;
            r_upd_vld     <= 1'b0;
            r_upd_idx     <= '0;
            r_upd_tag     <= '0;
            r_upd_target  <= 32'd0;
            r_upd_taken   <= 1'b0;
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_upd_vld <= w_resolve;
            if (w_resolve) begin
                r_upd_idx    <= pc_e[IDX_W+1:2];
                r_upd_tag    <= pc_e[31:32-TAG_W];
                r_upd_target <= w_target;
                r_upd_taken  <= w_taken;
                if (r_br_cnt != '1) begin
                    r_br_cnt <= r_br_cnt + CNT_ONE;
                end
                if (w_mispredict) begin
                    r_redirect_pc <= w_next_pc;
                    if (r_mispred_cnt != '1) begin
                        r_mispred_cnt <= r_mispred_cnt + CNT_ONE;
                    end
                end
            end
        end
    end

    assign upd_vld     = r_upd_vld;
    assign upd_idx     = r_upd_idx;
    assign upd_tag     = r_upd_tag;
    assign upd_target  = r_upd_target;
    assign upd_taken   = r_upd_taken;
    assign br_cnt      = r_br_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
//  tb_branch_resolve_unit
//  Directed self-checking bench for branch_resolve_unit.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_e;
    logic        stall_e;
    logic [31:0] instr_e;
    logic [31:0] pc_e;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm_e;
    logic [31:0] pc_d;
    logic        redirect_rdy;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        flush_d_e;
    logic        upd_vld;
    logic [9:0]  upd_idx;
    logic [19:0] upd_tag;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.IDX_W(10), .TAG_W(20), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_e      (valid_e),
        .stall_e      (stall_e),
        .instr_e      (instr_e),
        .pc_e         (pc_e),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .imm_e        (imm_e),
        .pc_d         (pc_d),
        .redirect_rdy (redirect_rdy),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .flush_d_e    (flush_d_e),
        .upd_vld      (upd_vld),
        .upd_idx      (upd_idx),
        .upd_tag      (upd_tag),
        .upd_target   (upd_target),
        .upd_taken    (upd_taken),
        .br_cnt       (br_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
        return {17'd0, f3, 5'd0, op};
    endfunction

    // Inputs change on the falling edge so the DUT sees them stable at posedge.
    task automatic drv(input logic v, input logic [2:0] f3, input logic [6:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [31:0] pcd);
        valid_e = v;
        instr_e = mk(f3, op);
        rs1_val = a;
        rs2_val = b;
        imm_e   = imm;
        pc_e    = pc;
        pc_d    = pcd;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall_e = 1'b0; redirect_rdy = 1'b0;
        drv(1'b0, 3'b000, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        step();
        chk("rst_redirect_vld", {31'd0, redirect_vld}, 32'd0);
        chk("rst_upd_vld",      {31'd0, upd_vld}, 32'd0);
        chk("rst_br_cnt",       br_cnt, 32'd0);
        rst = 1'b0;

        // BEQ taken, correctly predicted
        drv(1'b1, 3'b000, OP_B, 32'd5, 32'd5, 32'h20, 32'h100, 32'h120);
        step();
        drv(1'b0, 3'b000, OP_B, 32'd0, 32'd0, 32'd0, 32'h0, 32'h0);
        chk("beq_upd_vld",    {31'd0, upd_vld}, 32'd1);
        chk("beq_upd_taken",  {31'd0, upd_taken}, 32'd1);
        chk("beq_upd_target", upd_target, 32'h120);
        chk("beq_upd_idx",    {22'd0, upd_idx}, 32'h40);
        chk("beq_upd_tag",    {12'd0, upd_tag}, 32'h0);
        chk("beq_br_cnt",     br_cnt, 32'd1);
        chk("beq_no_redir",   {31'd0, redirect_vld}, 32'd0);
        step();
        chk("beq_upd_pulse",  {31'd0, upd_vld}, 32'd0);

        // BLT signed taken, mispredicted; redirect held while rdy low
        drv(1'b1, 3'b100, OP_B, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 32'h204);
        step();
        chk("blt_mispred_cnt", mispred_cnt, 32'd1);
        chk("blt_br_cnt",      br_cnt, 32'd2);
        drv(1'b1, 3'b001, OP_B, 32'd1, 32'd2, 32'h10, 32'h300, 32'h304);
        for (int k = 0; k < 4; k++) begin
            redirect_rdy = (k == 3);
            chk($sformatf("hold%0d_vld", k),   {31'd0, redirect_vld}, 32'd1);
            chk($sformatf("hold%0d_pc", k),    redirect_pc, 32'h240);
            chk($sformatf("hold%0d_flush", k), {31'd0, flush_d_e}, 32'd1);
            if (k > 0) chk($sformatf("hold%0d_upd", k), {31'd0, upd_vld}, 32'd0);
            chk($sformatf("hold%0d_br", k),    br_cnt, 32'd2);
            step();
        end
        valid_e = 1'b0; redirect_rdy = 1'b0;
        chk("acc_vld",   {31'd0, redirect_vld}, 32'd0);
        chk("acc_flush", {31'd0, flush_d_e}, 32'd0);
        chk("acc_pc",    redirect_pc, 32'd0);
        chk("acc_upd",   {31'd0, upd_vld}, 32'd0);
        chk("acc_br",    br_cnt, 32'd2);

        // JALR clears bit 0 of the sum
        drv(1'b1, 3'b000, OP_JALR, 32'h1003, 32'd0, 32'd0, 32'h400, 32'h1002);
        step();
        valid_e = 1'b0;
        chk("jalr_target", upd_target, 32'h1002);
        chk("jalr_taken",  {31'd0, upd_taken}, 32'd1);
        chk("jalr_redir",  {31'd0, redirect_vld}, 32'd0);
        chk("jalr_br",     br_cnt, 32'd3);

        // BLTU unsigned: 0xFFFFFFFF is not below 1
        drv(1'b1, 3'b110, OP_B, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h500, 32'h504);
        step();
        valid_e = 1'b0;
        chk("bltu_taken",   {31'd0, upd_taken}, 32'd0);
        chk("bltu_redir",   {31'd0, redirect_vld}, 32'd0);
        chk("bltu_br",      br_cnt, 32'd4);
        chk("bltu_mispred", mispred_cnt, 32'd1);

        // Stalled BEQ resolves once when stall drops
        drv(1'b1, 3'b000, OP_B, 32'd7, 32'd7, 32'h8, 32'h600, 32'h608);
        stall_e = 1'b1;
        step();
        chk("stall0_upd", {31'd0, upd_vld}, 32'd0);
        step();
        chk("stall1_upd", {31'd0, upd_vld}, 32'd0);
        chk("stall_br",   br_cnt, 32'd4);
        stall_e = 1'b0;
        step();
        valid_e = 1'b0;
        chk("unstall_upd", {31'd0, upd_vld}, 32'd1);
        chk("unstall_br",  br_cnt, 32'd5);
        step();
        chk("unstall_once", br_cnt, 32'd5);

        // Reset while holding a redirect
        drv(1'b1, 3'b001, OP_B, 32'd1, 32'd2, 32'h100, 32'h700, 32'h704);
        step();
        valid_e = 1'b0;
        chk("bne_redir_pc", redirect_pc, 32'h800);
        chk("bne_mispred",  mispred_cnt, 32'd2);
        chk("bne_br",       br_cnt, 32'd6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("hrst_vld",     {31'd0, redirect_vld}, 32'd0);
        chk("hrst_pc",      redirect_pc, 32'd0);
        chk("hrst_flush",   {31'd0, flush_d_e}, 32'd0);
        chk("hrst_upd",     {31'd0, upd_vld}, 32'd0);
        chk("hrst_br",      br_cnt, 32'd0);
        chk("hrst_mispred", mispred_cnt, 32'd0);

        // JAL with negative offset, mispredicted, accepted immediately
        drv(1'b1, 3'b000, OP_JAL, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h900, 32'h904);
        step();
        valid_e = 1'b0;
        redirect_rdy = 1'b1;
        chk("jal_redir_pc", redirect_pc, 32'h8F0);
        chk("jal_mispred",  mispred_cnt, 32'd1);
        step();
        redirect_rdy = 1'b0;
        chk("jal_released", {31'd0, redirect_vld}, 32'd0);

        // Saturation of br_cnt
        force dut.r_br_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_br_cnt;
        drv(1'b1, 3'b000, OP_B, 32'd3, 32'd3, 32'h4, 32'hA00, 32'hA04);
        step();
        valid_e = 1'b0;
        chk("sat_upd", {31'd0, upd_vld}, 32'd1);
        chk("sat_br",  br_cnt, 32'hFFFF_FFFF);

        // Reserved funct3 010 is not control flow
        drv(1'b1, 3'b010, OP_B, 32'd3, 32'd3, 32'h4, 32'hB00, 32'hB08);
        step();
        valid_e = 1'b0;
        chk("f3_010_upd",   {31'd0, upd_vld}, 32'd0);
        chk("f3_010_redir", {31'd0, redirect_vld}, 32'd0);
        chk("f3_010_mis",   mispred_cnt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
